ingress_table_cfg_ctrl: RTL and testbench

- Sequences the single write port of the ingress L4 hash table.
- After reset, it fills every table entry from the small init ROM, spreading ROM entries round-robin across the table. It then raises reset_done.
- At runtime it accepts single-entry config updates from a NoC-side config requester. Before each write it fences parser lookups and waits for the table to go idle, so no lookup ever reads a half-updated entry.
- Sits between the init ROM, the hash table write port and the parser→table handshake gate in the ingress load-balance tile.

---
 rtl/ingress_table_cfg_ctrl_if.sv | 22 ++
 rtl/ingress_table_cfg_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ingress_table_cfg_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ingress_table_cfg_ctrl_if.sv
// Config-update channel between the NoC-side requester and the table config controller.
interface ingress_table_cfg_ctrl_if #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 16
);
  logic              cfg_req_val;
  logic [ADDR_W-1:0] cfg_req_addr;
  logic [DATA_W-1:0] cfg_req_data;
  logic              cfg_req_rdy;
  logic              cfg_resp_val;
  logic              cfg_resp_rdy;

  modport master (
    output cfg_req_val, cfg_req_addr, cfg_req_data, cfg_resp_rdy,
    input  cfg_req_rdy, cfg_resp_val
  );

  modport slave (
    input  cfg_req_val, cfg_req_addr, cfg_req_data, cfg_resp_rdy,
    output cfg_req_rdy, cfg_resp_val
  );
endinterface

// File: rtl/ingress_table_cfg_ctrl.sv
// Owns the ingress hash table write port: fills it from the init ROM after reset,
// then applies single-entry config updates behind a lookup fence.
module ingress_table_cfg_ctrl #(
  parameter int TABLE_ELS_LOG_2   = 6,
  parameter int INIT_TABLE_ELS    = 4,
  parameter int INIT_TABLE_ADDR_W = 2,
  parameter int TABLE_DATA_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  output logic                         init_table_rd,
  output logic [INIT_TABLE_ADDR_W-1:0] init_table_addr,
  input  logic [TABLE_DATA_W-1:0]      init_table_rd_data,
  output logic                         wr_req_val,
  output logic [TABLE_ELS_LOG_2-1:0]   wr_req_addr,
  output logic [TABLE_DATA_W-1:0]      wr_req_data,
  input  logic                         wr_req_rdy,
  input  logic                         table_idle,
  output logic                         lookup_en,
  output logic                         reset_done,
  ingress_table_cfg_ctrl_if.slave      cfg
);

  typedef enum logic [2:0] {
    INIT_RD   = 3'd0,
    INIT_WR   = 3'd1,
    IDLE      = 3'd2,
    CFG_DRAIN = 3'd3,
    CFG_WR    = 3'd4,
    CFG_RESP  = 3'd5
  } state_e;

  localparam logic [TABLE_ELS_LOG_2-1:0]   TBL_LAST = {TABLE_ELS_LOG_2{1'b1}};
  localparam logic [INIT_TABLE_ADDR_W-1:0] ROM_LAST = INIT_TABLE_ADDR_W'(INIT_TABLE_ELS - 1);

  state_e                         state_r;
  state_e                         next_state_s;
  logic [TABLE_ELS_LOG_2-1:0]     tbl_idx_r;
  logic [INIT_TABLE_ADDR_W-1:0]   rom_idx_r;
  logic                           first_r;
  logic [TABLE_ELS_LOG_2-1:0]     wr_addr_r;
  logic [TABLE_DATA_W-1:0]        wr_data_r;
  logic [TABLE_ELS_LOG_2-1:0]     cfg_addr_r;
  logic [TABLE_DATA_W-1:0]        cfg_data_r;
  logic                           done_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= INIT_RD;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      INIT_RD: begin
        next_state_s = INIT_WR;
      end
      INIT_WR: begin
        if (wr_req_rdy) begin
          if (tbl_idx_r == TBL_LAST) begin
            next_state_s = IDLE;
          end else begin
            next_state_s = INIT_RD;
          end
        end else begin
          next_state_s = INIT_WR;
        end
      end
      IDLE: begin
        if (cfg.cfg_req_val) begin
          next_state_s = CFG_DRAIN;
        end else begin
          next_state_s = IDLE;
        end
      end
      CFG_DRAIN: begin
        if (table_idle) begin
          next_state_s = CFG_WR;
        end else begin
          next_state_s = CFG_DRAIN;
        end
      end
      CFG_WR: begin
        if (wr_req_rdy) begin
          next_state_s = CFG_RESP;
        end else begin
          next_state_s = CFG_WR;
        end
      end
      CFG_RESP: begin
        if (cfg.cfg_resp_rdy) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = CFG_RESP;
        end
      end
      default: begin
        next_state_s = INIT_RD;
      end
    endcase
  end

  // Output decode from the registered state; ROM strobe is masked while rst is held.
  always_comb begin
    init_table_rd    = 1'b0;
    wr_req_val       = 1'b0;
    lookup_en        = 1'b0;
    cfg.cfg_req_rdy  = 1'b0;
    cfg.cfg_resp_val = 1'b0;
    case (state_r)
      INIT_RD: begin
        if (rst) begin
          init_table_rd = 1'b0;
        end else begin
          init_table_rd = 1'b1;
        end
      end
      INIT_WR: begin
        wr_req_val = 1'b1;
      end
      IDLE: begin
        lookup_en       = 1'b1;
        cfg.cfg_req_rdy = 1'b1;
      end
      CFG_DRAIN: begin
        lookup_en = 1'b0;
      end
      CFG_WR: begin
        wr_req_val = 1'b1;
      end
      CFG_RESP: begin
        lookup_en        = 1'b1;
        cfg.cfg_resp_val = 1'b1;
      end
      default: begin
        lookup_en = 1'b0;
      end
    endcase
  end

  // Counters, write-port holding registers and latched config request.
  always_ff @(posedge clk) begin
    if (rst) begin
      tbl_idx_r  <= {TABLE_ELS_LOG_2{1'b0}};
      rom_idx_r  <= {INIT_TABLE_ADDR_W{1'b0}};
      first_r    <= 1'b0;
      wr_addr_r  <= {TABLE_ELS_LOG_2{1'b0}};
      wr_data_r  <= {TABLE_DATA_W{1'b0}};
      cfg_addr_r <= {TABLE_ELS_LOG_2{1'b0}};
      cfg_data_r <= {TABLE_DATA_W{1'b0}};
      done_r     <= 1'b0;
    end else begin
      first_r <= (state_r == INIT_RD);
      case (state_r)
        INIT_RD: begin
          wr_addr_r <= tbl_idx_r;
        end
        INIT_WR: begin
          // ROM data is only valid in the first write cycle, so park it here.
          if (first_r) begin
            wr_data_r <= init_table_rd_data;
          end
          if (wr_req_rdy) begin
            tbl_idx_r <= tbl_idx_r + TABLE_ELS_LOG_2'(1);
            if (rom_idx_r == ROM_LAST) begin
              rom_idx_r <= {INIT_TABLE_ADDR_W{1'b0}};
            end else begin
              rom_idx_r <= rom_idx_r + INIT_TABLE_ADDR_W'(1);
            end
            if (tbl_idx_r == TBL_LAST) begin
              done_r <= 1'b1;
            end
          end
        end
        IDLE: begin
          if (cfg.cfg_req_val) begin
            cfg_addr_r <= cfg.cfg_req_addr;
            cfg_data_r <= cfg.cfg_req_data;
          end
        end
        CFG_DRAIN: begin
          if (table_idle) begin
            wr_addr_r <= cfg_addr_r;
            wr_data_r <= cfg_data_r;
          end
        end
        default: begin
          done_r <= done_r;
        end
      endcase
    end
  end

  assign init_table_addr = rom_idx_r;
  assign wr_req_addr     = wr_addr_r;
  assign wr_req_data     = ((state_r == INIT_WR) && first_r) ? init_table_rd_data : wr_data_r;
  assign reset_done      = done_r;

endmodule

// File: tb/tb_ingress_table_cfg_ctrl.sv
// Directed bench: init fill, stalled init, config update, drain fence, early config, reset mid-config.
module tb_ingress_table_cfg_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters, 64 entries, 4 ROM entries.
  logic        rst;
  logic        rd_a;
  logic [1:0]  addr_a;
  logic [15:0] rd_data_a;
  logic        wr_val_a;
  logic [5:0]  wr_addr_a;
  logic [15:0] wr_data_a;
  logic        wr_rdy_a;
  logic        idle_a;
  logic        lookup_a;
  logic        done_a;
  ingress_table_cfg_ctrl_if #(.ADDR_W(6), .DATA_W(16)) cfg_a ();

  ingress_table_cfg_ctrl dut (
    .clk(clk), .rst(rst),
    .init_table_rd(rd_a), .init_table_addr(addr_a), .init_table_rd_data(rd_data_a),
    .wr_req_val(wr_val_a), .wr_req_addr(wr_addr_a), .wr_req_data(wr_data_a), .wr_req_rdy(wr_rdy_a),
    .table_idle(idle_a), .lookup_en(lookup_a), .reset_done(done_a), .cfg(cfg_a)
  );

  // DUT B: 8 entries, 3 ROM entries, stalled write port.
  logic        rst_b;
  logic        rd_b;
  logic [1:0]  addr_b;
  logic [15:0] rd_data_b;
  logic        wr_val_b;
  logic [2:0]  wr_addr_b;
  logic [15:0] wr_data_b;
  logic        wr_rdy_b;
  logic        idle_b;
  logic        lookup_b;
  logic        done_b;
  ingress_table_cfg_ctrl_if #(.ADDR_W(3), .DATA_W(16)) cfg_b ();

  ingress_table_cfg_ctrl #(
    .TABLE_ELS_LOG_2(3), .INIT_TABLE_ELS(3), .INIT_TABLE_ADDR_W(2), .TABLE_DATA_W(16)
  ) dut_b (
    .clk(clk), .rst(rst_b),
    .init_table_rd(rd_b), .init_table_addr(addr_b), .init_table_rd_data(rd_data_b),
    .wr_req_val(wr_val_b), .wr_req_addr(wr_addr_b), .wr_req_data(wr_data_b), .wr_req_rdy(wr_rdy_b),
    .table_idle(idle_b), .lookup_en(lookup_b), .reset_done(done_b), .cfg(cfg_b)
  );

  logic [15:0] rom_a [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] rom_b [4] = '{16'h00A1, 16'h00B2, 16'h00C3, 16'hDEAD};

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ROM models: data valid only in the cycle after the strobe.
  always @(posedge clk) begin
    rd_data_a <= rd_a ? rom_a[addr_a] : 16'hDEAD;
    rd_data_b <= rd_b ? rom_b[addr_b] : 16'hDEAD;
  end

  logic [15:0] tbl_a [64];
  int          wr_cnt_a = 0;
  logic [5:0]  first_addr_a = 6'd63;
  always @(negedge clk) begin
    if (rst) begin
      wr_cnt_a <= 0;
    end else if (wr_val_a && wr_rdy_a) begin
      tbl_a[wr_addr_a] <= wr_data_a;
      if (wr_cnt_a == 0) first_addr_a <= wr_addr_a;
      wr_cnt_a <= wr_cnt_a + 1;
    end
  end

  logic [15:0] tbl_b [8];
  int          wr_cnt_b = 0;
  logic        prev_val_b = 1'b0;
  logic        prev_rdy_b = 1'b0;
  logic [2:0]  prev_addr_b = 3'd0;
  logic [15:0] prev_data_b = 16'd0;
  always @(negedge clk) begin
    if (rst_b) begin
      wr_cnt_b   <= 0;
      prev_val_b <= 1'b0;
      prev_rdy_b <= 1'b0;
    end else begin
      if (wr_val_b && prev_val_b && !prev_rdy_b) begin
        chk("stall_addr_stable", {29'd0, wr_addr_b}, {29'd0, prev_addr_b});
        chk("stall_data_stable", {16'd0, wr_data_b}, {16'd0, prev_data_b});
      end
      if (wr_val_b && wr_rdy_b) begin
        tbl_b[wr_addr_b] <= wr_data_b;
        wr_cnt_b <= wr_cnt_b + 1;
      end
      prev_val_b  <= wr_val_b;
      prev_rdy_b  <= wr_rdy_b;
      prev_addr_b <= wr_addr_b;
      prev_data_b <= wr_data_b;
    end
  end

  // DUT B stimulus: write-ready pattern 1,0,0,1 repeating.
  initial begin
    int ph;
    ph = 0;
    rst_b = 1'b1;
    idle_b = 1'b1;
    wr_rdy_b = 1'b1;
    cfg_b.cfg_req_val = 1'b0;
    cfg_b.cfg_req_addr = 3'd0;
    cfg_b.cfg_req_data = 16'd0;
    cfg_b.cfg_resp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_b = 1'b0;
    forever begin
      wr_rdy_b = ((ph % 4) == 0) || ((ph % 4) == 3);
      ph++;
      @(posedge clk);
      #1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_done(output int edges, output int bad);
    edges = 0;
    bad = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_a) begin
        edges = i;
        break;
      end
      if (lookup_a || cfg_a.cfg_req_rdy || cfg_a.cfg_resp_val) bad++;
    end
  endtask

  task automatic wait_resp(output int seen);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (cfg_a.cfg_resp_val) begin
        seen = 1;
        break;
      end
    end
  endtask

  initial begin
    int edges;
    int bad;
    int seen;
    rst = 1'b1;
    wr_rdy_a = 1'b1;
    idle_a = 1'b1;
    cfg_a.cfg_req_val = 1'b1;
    cfg_a.cfg_req_addr = 6'd7;
    cfg_a.cfg_req_data = 16'h0707;
    cfg_a.cfg_resp_rdy = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_init_rd", {31'd0, rd_a}, 32'd0);
    chk("rst_wr_val", {31'd0, wr_val_a}, 32'd0);
    chk("rst_lookup_en", {31'd0, lookup_a}, 32'd0);
    chk("rst_reset_done", {31'd0, done_a}, 32'd0);
    chk("rst_cfg_rdy", {31'd0, cfg_a.cfg_req_rdy}, 32'd0);
    chk("rst_resp_val", {31'd0, cfg_a.cfg_resp_val}, 32'd0);
    chk("rst_rom_addr", {30'd0, addr_a}, 32'd0);
    chk("rst_wr_addr", {26'd0, wr_addr_a}, 32'd0);
    chk("rst_wr_data", {16'd0, wr_data_a}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Init fill with an early config request pending the whole time.
    wait_done(edges, bad);
    chk("init_done_edges", edges, 32'd128);
    chk("init_fence_and_no_accept", bad, 32'd0);
    chk("init_write_count", wr_cnt_a, 32'd64);
    chk("early_cfg_rdy", {31'd0, cfg_a.cfg_req_rdy}, 32'd1);
    @(posedge clk);
    #1 cfg_a.cfg_req_val = 1'b0;
    wait_resp(seen);
    chk("early_cfg_resp", seen, 32'd1);
    @(negedge clk);
    chk("tbl_idx0", {16'd0, tbl_a[0]}, 32'h1111);
    chk("tbl_idx1", {16'd0, tbl_a[1]}, 32'h2222);
    chk("tbl_idx4", {16'd0, tbl_a[4]}, 32'h1111);
    chk("tbl_idx6", {16'd0, tbl_a[6]}, 32'h3333);
    chk("tbl_idx63", {16'd0, tbl_a[63]}, 32'h4444);
    chk("early_cfg_override", {16'd0, tbl_a[7]}, 32'h0707);
    chk("early_write_count", wr_cnt_a, 32'd65);

    // Config update with table idle.
    @(posedge clk);
    #1;
    cfg_a.cfg_req_val = 1'b1;
    cfg_a.cfg_req_addr = 6'd5;
    cfg_a.cfg_req_data = 16'h0203;
    @(negedge clk);
    chk("cfg_rdy_idle", {31'd0, cfg_a.cfg_req_rdy}, 32'd1);
    chk("cfg_lookup_idle", {31'd0, lookup_a}, 32'd1);
    @(posedge clk);
    #1 cfg_a.cfg_req_val = 1'b0;
    @(negedge clk);
    chk("cfg_drain_lookup", {31'd0, lookup_a}, 32'd0);
    chk("cfg_drain_wr_val", {31'd0, wr_val_a}, 32'd0);
    @(negedge clk);
    chk("cfg_wr_lookup", {31'd0, lookup_a}, 32'd0);
    chk("cfg_wr_val", {31'd0, wr_val_a}, 32'd1);
    chk("cfg_wr_addr", {26'd0, wr_addr_a}, 32'd5);
    chk("cfg_wr_data", {16'd0, wr_data_a}, 32'h0203);
    @(negedge clk);
    chk("cfg_resp_val", {31'd0, cfg_a.cfg_resp_val}, 32'd1);
    chk("cfg_resp_lookup", {31'd0, lookup_a}, 32'd1);
    @(negedge clk);
    chk("cfg_resp_dropped", {31'd0, cfg_a.cfg_resp_val}, 32'd0);
    chk("cfg_tbl_idx5", {16'd0, tbl_a[5]}, 32'h0203);

    // Drain fence: table busy for 7 cycles after accept.
    @(posedge clk);
    #1;
    cfg_a.cfg_req_val = 1'b1;
    cfg_a.cfg_req_addr = 6'd9;
    cfg_a.cfg_req_data = 16'h0909;
    idle_a = 1'b0;
    @(posedge clk);
    #1 cfg_a.cfg_req_val = 1'b0;
    bad = 0;
    repeat (7) begin
      @(negedge clk);
      if (wr_val_a || lookup_a) bad++;
      @(posedge clk);
    end
    #1 idle_a = 1'b1;
    chk("fence_busy_span", bad, 32'd0);
    @(negedge clk);
    chk("fence_last_drain", {31'd0, wr_val_a}, 32'd0);
    @(negedge clk);
    chk("fence_wr_val", {31'd0, wr_val_a}, 32'd1);
    chk("fence_wr_addr", {26'd0, wr_addr_a}, 32'd9);
    wait_resp(seen);
    chk("fence_resp", seen, 32'd1);
    @(negedge clk);
    chk("fence_tbl_idx9", {16'd0, tbl_a[9]}, 32'h0909);

    // Reset while stalled in the config write.
    @(posedge clk);
    #1;
    cfg_a.cfg_req_val = 1'b1;
    cfg_a.cfg_req_addr = 6'd2;
    cfg_a.cfg_req_data = 16'h0BAD;
    wr_rdy_a = 1'b0;
    @(posedge clk);
    #1 cfg_a.cfg_req_val = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midcfg_wr_val", {31'd0, wr_val_a}, 32'd1);
    chk("midcfg_wr_addr", {26'd0, wr_addr_a}, 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    wr_rdy_a = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midcfg_rst_done", {31'd0, done_a}, 32'd0);
    chk("midcfg_rst_resp", {31'd0, cfg_a.cfg_resp_val}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_done(edges, bad);
    chk("reinit_done_edges", edges, 32'd128);
    chk("reinit_fence_no_resp", bad, 32'd0);
    chk("reinit_first_idx", {26'd0, first_addr_a}, 32'd0);
    chk("reinit_write_count", wr_cnt_a, 32'd64);
    chk("reinit_tbl_idx2", {16'd0, tbl_a[2]}, 32'h3333);
    chk("reinit_tbl_idx5", {16'd0, tbl_a[5]}, 32'h2222);
    chk("reinit_tbl_idx7", {16'd0, tbl_a[7]}, 32'h4444);
    chk("reinit_tbl_idx9", {16'd0, tbl_a[9]}, 32'h2222);

    // Stalled init on DUT B (finished long ago).
    chk("b_reset_done", {31'd0, done_b}, 32'd1);
    chk("b_lookup_en", {31'd0, lookup_b}, 32'd1);
    chk("b_cfg_rdy", {31'd0, cfg_b.cfg_req_rdy}, 32'd1);
    chk("b_resp_val", {31'd0, cfg_b.cfg_resp_val}, 32'd0);
    chk("b_write_count", wr_cnt_b, 32'd8);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("b_tbl_idx%0d", k), {16'd0, tbl_b[k]}, {16'd0, rom_b[k % 3]});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
